// File: rtl/common.sv
// Shared types and opcode/funct3 constants for the decode stage.
// Optional REGFILE_BYPASS_EN changes register-file read timing (see register_file).
package common;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_type;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } control_type;

  localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPCODE_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADDI  = 3'b000;
  localparam logic [2:0] FUNCT3_SLTI  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTIU = 3'b011;
  localparam logic [2:0] FUNCT3_XORI  = 3'b100;
  localparam logic [2:0] FUNCT3_ORI   = 3'b110;
  localparam logic [2:0] FUNCT3_ANDI  = 3'b111;
  localparam logic [2:0] FUNCT3_BEQ   = 3'b000;
  localparam logic [2:0] FUNCT3_BNE   = 3'b001;
  localparam logic [2:0] FUNCT3_LW    = 3'b010;
  localparam logic [2:0] FUNCT3_SW    = 3'b010;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_R      = 2'b10;
  localparam logic [1:0] ALU_OP_I      = 2'b11;

endpackage

// File: rtl/decode_stage_if.sv
// Register-file access bundle: two combinational read ports and one clocked write port.
// No handshake: reads are always valid and writes commit on the rising clock edge when we=1.
interface decode_stage_if;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport master (
    output raddr1, raddr2, we, waddr, wdata,
    input  rdata1, rdata2
  );

  modport slave (
    input  raddr1, raddr2, we, waddr, wdata,
    output rdata1, rdata2
  );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit register file, x0 hard-wired to zero, synchronous active-high clear.
// REGFILE_BYPASS_EN: a read of the register being written returns the incoming data.
module register_file (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave rf
);

  logic [31:0] regs [32];
  logic        write_hit;

  assign write_hit = rf.we && (rf.waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) regs[k] <= '0;
    end else if (write_hit) begin
      regs[rf.waddr] <= rf.wdata;
    end
  end

  always_comb begin
    rf.rdata1 = (rf.raddr1 == 5'd0) ? 32'd0 : regs[rf.raddr1];
    rf.rdata2 = (rf.raddr2 == 5'd0) ? 32'd0 : regs[rf.raddr2];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so a same-cycle reader sees the new value.
    if (write_hit && (rf.raddr1 == rf.waddr)) rf.rdata1 = rf.wdata;
    if (write_hit && (rf.raddr2 == rf.waddr)) rf.rdata2 = rf.wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: register read, immediate generation, control decode, branch target.
// Fully combinational except the register file; REGFILE_BYPASS_EN enables write forwarding.
module decode_stage
  import common::*;
(
  input  logic            clk,
  input  logic            rst,
  input  instruction_type instruction,
  input  logic [31:0]     pc,
  input  logic            RegWrite,
  input  logic [4:0]      write_id,
  input  logic [31:0]     write_data,
  output logic [31:0]     data1,
  output logic [31:0]     data2,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output control_type     control,
  output logic [31:0]     pc_branch
);

  logic [31:0] i;
  decode_stage_if rf ();

  assign i = instruction;

  assign rs1 = instruction.rs1;
  assign rs2 = instruction.rs2;
  assign rd  = instruction.rd;

  assign rf.raddr1 = instruction.rs1;
  assign rf.raddr2 = instruction.rs2;
  assign rf.we     = RegWrite;
  assign rf.waddr  = write_id;
  assign rf.wdata  = write_data;
  assign data1     = rf.rdata1;
  assign data2     = rf.rdata2;

  register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  always_comb begin
    imm = 32'd0;
    case (instruction.opcode)
      OPCODE_I_TYPE,
      OPCODE_LOAD,
      OPCODE_JALR:   imm = {{20{i[31]}}, i[31:20]};
      OPCODE_STORE:  imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OPCODE_BRANCH: imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OPCODE_LUI,
      OPCODE_AUIPC:  imm = {i[31:12], 12'b0};
      OPCODE_JAL:    imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:       imm = 32'd0;
    endcase
  end

  // Wraps modulo 2^32 by construction of the 32-bit sum.
  assign pc_branch = pc + imm;

  always_comb begin
    control = '0;
    case (instruction.opcode)
      OPCODE_R_TYPE: begin
        control.reg_write = 1'b1;
        control.alu_op    = ALU_OP_R;
      end
      OPCODE_I_TYPE: begin
        control.reg_write = 1'b1;
        control.alu_src   = 1'b1;
        control.alu_op    = ALU_OP_I;
      end
      OPCODE_LOAD: begin
        control.reg_write  = 1'b1;
        control.mem_read   = 1'b1;
        control.mem_to_reg = 1'b1;
        control.alu_src    = 1'b1;
        control.alu_op     = ALU_OP_ADD;
      end
      OPCODE_STORE: begin
        control.mem_write = 1'b1;
        control.alu_src   = 1'b1;
        control.alu_op    = ALU_OP_ADD;
      end
      OPCODE_BRANCH: begin
        control.branch = 1'b1;
        control.alu_op = ALU_OP_BRANCH;
      end
      OPCODE_JAL: begin
        control.reg_write = 1'b1;
        control.jump      = 1'b1;
        control.alu_op    = ALU_OP_ADD;
      end
      OPCODE_JALR: begin
        control.reg_write = 1'b1;
        control.jump      = 1'b1;
        control.alu_src   = 1'b1;
        control.alu_op    = ALU_OP_ADD;
      end
      OPCODE_LUI,
      OPCODE_AUIPC: begin
        control.reg_write = 1'b1;
        control.alu_src   = 1'b1;
        control.alu_op    = ALU_OP_ADD;
      end
      default: control = '0;
    endcase
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table, register-file sequences, random decode.
// Expectations adapt to REGFILE_BYPASS_EN when the bench is built with it defined.
module tb_decode_stage;
  import common::*;

  logic            clk;
  logic            rst;
  instruction_type instruction;
  logic [31:0]     pc;
  logic            RegWrite;
  logic [4:0]      write_id;
  logic [31:0]     write_data;
  logic [31:0]     data1, data2;
  logic [4:0]      rs1, rs2, rd;
  logic [31:0]     imm;
  control_type     control;
  logic [31:0]     pc_branch;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs_m [32];

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .pc         (pc),
    .RegWrite   (RegWrite),
    .write_id   (write_id),
    .write_data (write_data),
    .data1      (data1),
    .data2      (data2),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .imm        (imm),
    .control    (control),
    .pc_branch  (pc_branch)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model update for the edge about to happen, then move 1 time unit past it.
  task automatic tick();
    if (rst) begin
      for (int k = 0; k < 32; k++) regs_m[k] = 32'd0;
    end else if (RegWrite && write_id != 5'd0) begin
      regs_m[write_id] = write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [4:0] id, input logic [31:0] val);
    RegWrite = 1'b1; write_id = id; write_data = val;
    tick();
    RegWrite = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && write_id != 5'd0 && idx == write_id) return write_data;
`endif
    return regs_m[idx];
  endfunction

  function automatic logic [31:0] sext(input int unsigned v, input int n);
    int unsigned half;
    half = 32'd1 << (n - 1);
    return (v ^ half) - half;
  endfunction

  // Immediate from the instruction format implied by the opcode.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h13 || op == 7'h03 || op == 7'h67) return sext(ins >> 20, 12);
    if (op == 7'h23) return sext({ins[31:25], ins[11:7]}, 12);
    if (op == 7'h63) return sext({ins[31], ins[7], ins[30:25], ins[11:8]}, 12) * 2;
    if (op == 7'h37 || op == 7'h17) return ins & 32'hFFFFF000;
    if (op == 7'h6F) return sext({ins[31], ins[19:12], ins[20], ins[30:21]}, 20) * 2;
    return 32'd0;
  endfunction

  typedef struct {
    logic [6:0] op;
    logic [8:0] ctl;
  } ctl_rec_t;

  ctl_rec_t ctl_tab [9];

  function automatic logic [8:0] mk(input bit rw, mr, mw, mtr, as, br, j, input logic [1:0] aop);
    return {rw, mr, mw, mtr, as, br, j, aop};
  endfunction

  function automatic logic [8:0] ref_ctl(input logic [6:0] op);
    foreach (ctl_tab[k]) if (ctl_tab[k].op == op) return ctl_tab[k].ctl;
    return 9'd0;
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pcb;
    logic [8:0]  ctl;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] r;
    logic [6:0]  ops [10];

    ctl_tab[0] = '{7'h33, mk(1,0,0,0,0,0,0,2'b10)};
    ctl_tab[1] = '{7'h13, mk(1,0,0,0,1,0,0,2'b11)};
    ctl_tab[2] = '{7'h03, mk(1,1,0,1,1,0,0,2'b00)};
    ctl_tab[3] = '{7'h23, mk(0,0,1,0,1,0,0,2'b00)};
    ctl_tab[4] = '{7'h63, mk(0,0,0,0,0,1,0,2'b01)};
    ctl_tab[5] = '{7'h6F, mk(1,0,0,0,0,0,1,2'b00)};
    ctl_tab[6] = '{7'h67, mk(1,0,0,0,1,0,1,2'b00)};
    ctl_tab[7] = '{7'h37, mk(1,0,0,0,1,0,0,2'b00)};
    ctl_tab[8] = '{7'h17, mk(1,0,0,0,1,0,0,2'b00)};

    vecs[0]  = '{"addi",     32'h00310193, 32'h0,        32'h3,        32'h3,        mk(1,0,0,0,1,0,0,2'b11)};
    vecs[1]  = '{"beq_100",  32'hFE000CE3, 32'h100,      32'hFFFFFFF8, 32'hF8,       mk(0,0,0,0,0,1,0,2'b01)};
    vecs[2]  = '{"beq_wrap", 32'hFE000CE3, 32'h4,        32'hFFFFFFF8, 32'hFFFFFFFC, mk(0,0,0,0,0,1,0,2'b01)};
    vecs[3]  = '{"sw",       32'hFE112E23, 32'h40,       32'hFFFFFFFC, 32'h3C,       mk(0,0,1,0,1,0,0,2'b00)};
    vecs[4]  = '{"lui",      32'h123450B7, 32'h0,        32'h12345000, 32'h12345000, mk(1,0,0,0,1,0,0,2'b00)};
    vecs[5]  = '{"auipc",    32'h12345097, 32'h10,       32'h12345000, 32'h12345010, mk(1,0,0,0,1,0,0,2'b00)};
    vecs[6]  = '{"jal",      32'h008000EF, 32'h20,       32'h8,        32'h28,       mk(1,0,0,0,0,0,1,2'b00)};
    vecs[7]  = '{"jalr",     32'hFFF100E7, 32'h200,      32'hFFFFFFFF, 32'h1FF,      mk(1,0,0,0,1,0,1,2'b00)};
    vecs[8]  = '{"lw",       32'h01012203, 32'h0,        32'h10,       32'h10,       mk(1,1,0,1,1,0,0,2'b00)};
    vecs[9]  = '{"add",      32'h002082B3, 32'h80,       32'h0,        32'h80,       mk(1,0,0,0,0,0,0,2'b10)};
    vecs[10] = '{"unknown",  32'hFFFFFFFF, 32'h44,       32'h0,        32'h44,       9'd0};
    vecs[11] = '{"jal_wrap", 32'h008000EF, 32'hFFFFFFFC, 32'h8,        32'h4,        mk(1,0,0,0,0,0,1,2'b00)};

    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    // reset
    rst = 1'b1; instruction = '0; pc = '0;
    RegWrite = 1'b0; write_id = '0; write_data = '0;
    for (int k = 0; k < 32; k++) regs_m[k] = 32'hDEADBEEF;
    tick(); tick();
    rst = 1'b0;

    for (int k = 0; k < 32; k++) begin
      instruction = {7'd0, 5'(31 - k), 5'(k), 3'd0, 5'd0, 7'h33};
      #1;
      check($sformatf("reset_x%0d_d1", k), data1, 32'd0);
      check($sformatf("reset_x%0d_d2", 31 - k), data2, 32'd0);
    end

    // write x2=5 then ADDI x3,x2,3
    drive_write(5'd2, 32'd5);
    instruction = 32'h00310193; pc = 32'h0;
    #1;
    check("addi_rs1", {27'd0, rs1}, 32'd2);
    check("addi_rd", {27'd0, rd}, 32'd3);
    check("addi_data1", data1, 32'd5);
    check("addi_imm", imm, 32'd3);
    check("addi_ctl", {23'd0, control}, {23'd0, mk(1,0,0,0,1,0,0,2'b11)});

    // write to x0 is ignored
    drive_write(5'd0, 32'hFFFFFFFF);
    instruction = {7'd0, 5'd0, 5'd0, 3'd0, 5'd0, 7'h33};
    #1;
    check("x0_d1", data1, 32'd0);
    check("x0_d2", data2, 32'd0);

    // vector table
    foreach (vecs[k]) begin
      instruction = vecs[k].instr; pc = vecs[k].pc;
      #1;
      check({vecs[k].name, "_imm"}, imm, vecs[k].imm);
      check({vecs[k].name, "_pcb"}, pc_branch, vecs[k].pcb);
      check({vecs[k].name, "_ctl"}, {23'd0, control}, {23'd0, vecs[k].ctl});
    end

    // same-cycle read of the register being written
    drive_write(5'd5, 32'h11111111);
    instruction = {7'd0, 5'd0, 5'd5, 3'd0, 5'd0, 7'h13};
    RegWrite = 1'b1; write_id = 5'd5; write_data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_before_edge", data1, 32'hA5A5A5A5);
`else
    check("nobypass_before_edge", data1, 32'h11111111);
`endif
    tick();
    RegWrite = 1'b0;
    #1;
    check("after_edge", data1, 32'hA5A5A5A5);

    // reset mid-operation discards a simultaneous write
    drive_write(5'd7, 32'h77777777);
    rst = 1'b1; RegWrite = 1'b1; write_id = 5'd9; write_data = 32'h99999999;
    tick();
    rst = 1'b0; RegWrite = 1'b0;
    instruction = {7'd0, 5'd9, 5'd7, 3'd0, 5'd0, 7'h33};
    #1;
    check("midrst_x7", data1, 32'd0);
    check("midrst_x9", data2, 32'd0);

    // randomized decode and register traffic against the model
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      instruction = r;
      pc = $urandom;
      RegWrite = 1'($urandom_range(0, 1));
      write_id = 5'($urandom_range(0, 31));
      write_data = $urandom;
      #1;
      check("rnd_rs1", {27'd0, rs1}, {27'd0, r[19:15]});
      check("rnd_rs2", {27'd0, rs2}, {27'd0, r[24:20]});
      check("rnd_rd", {27'd0, rd}, {27'd0, r[11:7]});
      check("rnd_data1", data1, exp_read(r[19:15]));
      check("rnd_data2", data2, exp_read(r[24:20]));
      check("rnd_imm", imm, ref_imm(r));
      check("rnd_pcb", pc_branch, pc + ref_imm(r));
      check("rnd_ctl", {23'd0, control}, {23'd0, ref_ctl(r[6:0])});
      tick();
    end
    RegWrite = 1'b0;

    // final sweep of the whole register file
    for (int k = 0; k < 32; k++) begin
      instruction = {7'd0, 5'(31 - k), 5'(k), 3'd0, 5'd0, 7'h33};
      #1;
      check($sformatf("sweep_x%0d", k), data1, exp_read(5'(k)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
